// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and defaults for the pipeline hazard controller
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
    localparam logic [4:0] REG_ZERO        = 5'd0;
    localparam int         DEF_MEM_TIMEOUT = 16;
    localparam int         DEF_CNT_W       = 16;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, asynchronous active-low clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);
    logic [WIDTH-1:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_inc && r_cnt != '1)
            r_cnt <= r_cnt + WIDTH'(1);
    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the five-stage pipeline,
// with a memory-wait FSM that times out into a sticky error state.
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             EXMEM_branch,
    input  logic             EXMEM_zero,
    input  logic             Mem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             EXMEM_Write,
    output logic             PCSrc,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             MEMWB_Flush,
    output logic             Mem_Req,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] Stall_Cycles,
    output logic [CNT_W-1:0] Flush_Count
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    state_t          r_state, w_next;
    logic [WC_W-1:0] r_wait_cnt, w_wait_nxt;
    logic            r_mem_error;
    logic            w_acc, w_taken, w_lu, w_freeze, w_take, w_lu_stall;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wait_cnt  <= w_wait_nxt;
            r_mem_error <= r_mem_error | (w_next == ERR);
        end

    always_comb begin
        w_acc      = EXMEM_MemRead | EXMEM_MemWrite;
        w_taken    = EXMEM_branch & EXMEM_zero;
        w_lu       = IDEX_MemRead && IDEX_rt != REG_ZERO && (IDEX_rt == IFID_rs || IDEX_rt == IFID_rt);
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        case (r_state)
            RUN:
                if (w_acc && !Mem_Ready) begin
                    w_next     = WAIT;
                    w_wait_nxt = WC_W'(1);
                end
            WAIT:
                if (Mem_Ready) begin
                    w_next     = RUN;
                    w_wait_nxt = '0;
                end else if (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1))
                    w_next = ERR;
                else
                    w_wait_nxt = r_wait_cnt + WC_W'(1);
            default: ;
        endcase
        // Freeze lifts in the very cycle Mem_Ready arrives, so taken/lu act there too
        w_freeze    = (r_state == ERR) || (r_state == WAIT && !Mem_Ready) ||
                      (r_state == RUN && w_acc && !Mem_Ready);
        w_take      = Rst_n && !w_freeze && w_taken;
        w_lu_stall  = Rst_n && !w_freeze && !w_taken && w_lu;
        PC_Write    = Rst_n && !w_freeze && !w_lu_stall;
        IFID_Write  = PC_Write;
        EXMEM_Write = Rst_n && !w_freeze;
        PCSrc       = w_take;
        IFID_Flush  = !Rst_n || w_take;
        IDEX_Flush  = !Rst_n || w_take || w_lu_stall;
        EXMEM_Flush = !Rst_n || w_take;
        MEMWB_Flush = !Rst_n || w_freeze;
        Mem_Req     = Rst_n && (r_state == RUN ? w_acc : r_state == WAIT);
        Mem_Error   = r_mem_error;
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .i_clk  (Clk),
        .i_rst_n(Rst_n),
        .i_inc  (!PC_Write),
        .o_cnt  (Stall_Cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .i_clk  (Clk),
        .i_rst_n(Rst_n),
        .i_inc  (w_take),
        .o_cnt  (Flush_Count)
    );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: scoreboard bench with a cycle-level reference model
module tb_pipeline_hazard_controller;
    localparam int T     = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs, rt;
        logic       idex_mr;
        logic [4:0] idex_rt;
        logic       mr, mw, br, z, rdy;
    } in_t;

    typedef struct packed {
        logic [9:0]       ctrl;
        logic [CNT_W-1:0] stall, flush;
    } exp_t;

    logic Clk = 1'b0, Rst_n = 1'b1;
    logic [4:0] IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
    logic IDEX_MemRead = 0, EXMEM_MemRead = 0, EXMEM_MemWrite = 0;
    logic EXMEM_branch = 0, EXMEM_zero = 0, Mem_Ready = 0;
    logic PC_Write, IFID_Write, EXMEM_Write, PCSrc;
    logic IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush, Mem_Req, Mem_Error;
    logic [CNT_W-1:0] Stall_Cycles, Flush_Count;

    pipeline_hazard_controller #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_branch(EXMEM_branch), .EXMEM_zero(EXMEM_zero), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .EXMEM_Write(EXMEM_Write),
        .PCSrc(PCSrc), .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush),
        .EXMEM_Flush(EXMEM_Flush), .MEMWB_Flush(MEMWB_Flush), .Mem_Req(Mem_Req),
        .Mem_Error(Mem_Error), .Stall_Cycles(Stall_Cycles), .Flush_Count(Flush_Count)
    );

    always #5 Clk = ~Clk;

    exp_t sb[$];
    int   checks = 0, errors = 0;

    // Reference model: cycles the current access has gone unanswered, and the error latch
    int m_waited = 0, m_stall = 0, m_flush = 0;
    bit m_err = 0;

    function automatic in_t idle();
        in_t s;
        s       = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic cyc(input in_t s);
        bit   acc, taken, lu, frz, tk, lus, pcw, req;
        exp_t e;
        @(posedge Clk);
        #1;
        Rst_n = s.rst_n; IFID_rs = s.rs; IFID_rt = s.rt; IDEX_MemRead = s.idex_mr;
        IDEX_rt = s.idex_rt; EXMEM_MemRead = s.mr; EXMEM_MemWrite = s.mw;
        EXMEM_branch = s.br; EXMEM_zero = s.z; Mem_Ready = s.rdy;
        acc   = s.mr | s.mw;
        taken = s.br & s.z;
        lu    = s.idex_mr && s.idex_rt != 0 && (s.idex_rt == s.rs || s.idex_rt == s.rt);
        if (!s.rst_n) begin
            e.ctrl = 10'b000_0_1111_0_0;
            e.stall = '0; e.flush = '0;
            m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            req = m_err ? 1'b0 : (m_waited > 0 ? 1'b1 : acc);
            frz = m_err || ((m_waited > 0 || acc) && !s.rdy);
            tk  = !frz && taken;
            lus = !frz && !taken && lu;
            pcw = !frz && !lus;
            e.ctrl  = {pcw, pcw, !frz, tk, tk, tk | lus, tk, frz, req, m_err};
            e.stall = CNT_W'(m_stall);
            e.flush = CNT_W'(m_flush);
            if (!m_err && (m_waited > 0 || acc)) begin
                if (s.rdy) m_waited = 0;
                else begin
                    m_waited++;
                    if (m_waited == T) begin m_err = 1; m_waited = 0; end
                end
            end
            if (!pcw && m_stall < MAXC) m_stall++;
            if (tk && m_flush < MAXC) m_flush++;
        end
        sb.push_back(e);
    endtask

    always @(negedge Clk) begin
        exp_t       e;
        logic [9:0] act;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = {PC_Write, IFID_Write, EXMEM_Write, PCSrc, IFID_Flush, IDEX_Flush,
                   EXMEM_Flush, MEMWB_Flush, Mem_Req, Mem_Error};
            checks += 3;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL ctrl t=%0t got %b expected %b", $time, act, e.ctrl);
            end
            if (Stall_Cycles !== e.stall) begin
                errors++;
                $display("FAIL stall_cycles t=%0t got %0d expected %0d", $time, Stall_Cycles, e.stall);
            end
            if (Flush_Count !== e.flush) begin
                errors++;
                $display("FAIL flush_count t=%0t got %0d expected %0d", $time, Flush_Count, e.flush);
            end
        end
    end

    initial begin
        in_t s;
        s = idle(); s.rst_n = 0; repeat (3) cyc(s);
        repeat (3) cyc(idle());
        s = idle(); s.idex_mr = 1; s.idex_rt = 5; s.rs = 5; cyc(s); cyc(idle());
        s.idex_rt = 0; s.rs = 0; cyc(s); cyc(idle());
        s = idle(); s.br = 1; s.z = 1; s.idex_mr = 1; s.idex_rt = 5; s.rt = 5; cyc(s); cyc(idle());
        s = idle(); s.mr = 1; repeat (3) cyc(s); s.rdy = 1; cyc(s); cyc(idle());
        s = idle(); s.mw = 1; repeat (6) cyc(s); s.rst_n = 0; cyc(s); cyc(idle());
        s = idle(); s.br = 1; s.z = 1; repeat (20) cyc(s);
        for (int i = 0; i < 1500; i++) begin
            s.rst_n   = $urandom_range(99) != 0;
            s.rs      = 5'($urandom_range(3));
            s.rt      = 5'($urandom_range(3));
            s.idex_rt = 5'($urandom_range(3));
            s.idex_mr = $urandom_range(1) == 1;
            s.mr      = $urandom_range(4) == 0;
            s.mw      = $urandom_range(6) == 0;
            s.br      = $urandom_range(2) == 0;
            s.z       = $urandom_range(1) == 1;
            s.rdy     = $urandom_range(9) < 7;
            cyc(s);
        end
        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
